// File: rtl/fsmc_channel_fifo.sv
// fsmc_channel_fifo: register/FIFO stage downstream of fsmc_interface.
// Regions: TX data FIFO (cs=0), STATUS (1), CTRL (2), SCRATCH (3).
// The FIFO drains to on-chip logic over a first-word-fall-through valid/ready stream.
// Optional feature: define FSMC_FIFO_IRQ_EN to add the registered irq output.
module fsmc_channel_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned LVL_W = $clog2(DEPTH) + 1
`ifdef FSMC_FIFO_IRQ_EN
  ,
  parameter int unsigned IRQ_THRESH = 8
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  cs,
  input  logic        bus_wr,
  input  logic        bus_rd,
  input  logic [15:0] module_in,
  output logic [15:0] module_out,
  output logic [15:0] m_data,
  output logic        m_valid,
  input  logic        m_ready
`ifdef FSMC_FIFO_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  localparam logic [3:0] CS_DATA    = 4'd0;
  localparam logic [3:0] CS_STATUS  = 4'd1;
  localparam logic [3:0] CS_CTRL    = 4'd2;
  localparam logic [3:0] CS_SCRATCH = 4'd3;

  logic [15:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level;
  logic             overflow;
  logic             enable;
  logic             irq_mask;
  logic [15:0]      scratch;

  logic             full_c;
  logic             empty_c;
  logic             push_req_c;
  logic             push_c;
  logic             pop_c;
  logic             flush_c;
  logic             ovf_set_c;
  logic             ovf_clr_c;
  logic             ctrl_wr_c;
  logic             scratch_wr_c;
  logic [15:0]      status_c;
  logic [15:0]      rd_word_c;

  // Reads have no side effects; the strobe is accepted but unused.
  logic             bus_rd_unused;
  assign bus_rd_unused = bus_rd;

  // Stream side is taken straight from FIFO state (fall-through head).
  assign m_data  = mem[rd_ptr];
  assign m_valid = ~empty_c;

  // Strobe decode and FIFO accept/drop decisions.
  always_comb begin
    full_c       = 1'b0;
    empty_c      = 1'b0;
    push_req_c   = 1'b0;
    push_c       = 1'b0;
    pop_c        = 1'b0;
    flush_c      = 1'b0;
    ovf_set_c    = 1'b0;
    ovf_clr_c    = 1'b0;
    ctrl_wr_c    = 1'b0;
    scratch_wr_c = 1'b0;

    full_c       = (level == LVL_W'(DEPTH));
    empty_c      = (level == '0);
    ctrl_wr_c    = bus_wr & (cs == CS_CTRL);
    scratch_wr_c = bus_wr & (cs == CS_SCRATCH);
    flush_c      = ctrl_wr_c & module_in[1];
    ovf_clr_c    = bus_wr & (cs == CS_STATUS) & module_in[15];
    pop_c        = ~empty_c & m_ready;
    push_req_c   = bus_wr & (cs == CS_DATA) & enable;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_c       = push_req_c & (~full_c | pop_c);
    ovf_set_c    = push_req_c & full_c & ~pop_c;
  end

  // FIFO storage, pointers and level; flush overrides any same-cycle push/pop.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush_c) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_c) begin
        mem[wr_ptr] <= module_in;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push_c, pop_c})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Sticky overflow flag, cleared by W1C on STATUS bit 15; flush leaves it alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (ovf_clr_c) begin
      overflow <= 1'b0;
    end else if (ovf_set_c) begin
      overflow <= 1'b1;
    end
  end

  // Control and scratch registers; flush bit is a pulse and is never stored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable   <= 1'b1;
      irq_mask <= 1'b0;
      scratch  <= '0;
    end else begin
      if (ctrl_wr_c) begin
        enable   <= module_in[0];
        irq_mask <= module_in[2];
      end
      if (scratch_wr_c) begin
        scratch <= module_in;
      end
    end
  end

  // Read-back mux; DATA is write-only and unmapped selects read as zero.
  always_comb begin
    status_c  = '0;
    rd_word_c = '0;
    status_c  = {overflow, full_c, empty_c, 5'b0_0000, 8'(level)};
    case (cs)
      CS_STATUS:  rd_word_c = status_c;
      CS_CTRL:    rd_word_c = {13'd0, irq_mask, 1'b0, enable};
      CS_SCRATCH: rd_word_c = scratch;
      default:    rd_word_c = '0;
    endcase
  end

  // Registered read data, refreshed every cycle from the mux.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      module_out <= '0;
    end else begin
      module_out <= rd_word_c;
    end
  end

`ifdef FSMC_FIFO_IRQ_EN
  // Level/overflow interrupt, gated by the CTRL mask.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_mask & ((level >= LVL_W'(IRQ_THRESH)) | overflow);
    end
  end
`endif

endmodule
